// File: rtl/f3m_pkg.sv
// Shared GF(3) / GF(3^97) definitions for the f3m arithmetic units.
// Field polynomial P(x) = x^97 + x^12 + 2, trits packed two bits per coefficient.
package f3m_pkg;

    localparam int M     = 97;
    localparam int W     = 2 * M;
    // Euclid working registers carry one extra trit for the degree-M term of P
    localparam int RW    = 2 * (M + 1);
    localparam int DW    = 8;
    localparam int ITERS = 2 * M;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;

    localparam int TAP_HI  = 97;
    localparam int TAP_MID = 12;
    localparam int TAP_LO  = 0;

    localparam logic [RW-1:0] P_POLY = (RW'(1) << (2 * TAP_HI))
                                     | (RW'(1) << (2 * TAP_MID))
                                     | (RW'(T2) << (2 * TAP_LO));
    localparam logic [W-1:0]  F_ONE  = W'(T1);

    typedef enum logic [1:0] {
        LOAD,
        ITER,
        FIN,
        DONE
    } phase_t;

    function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Negation swaps 1 and 2, which is just a bit swap in this encoding
    function automatic logic [1:0] f3_neg(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [1:0] f3_sub(input logic [1:0] a, input logic [1:0] b);
        return f3_add(a, f3_neg(b));
    endfunction

    function automatic logic [1:0] f3_mul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] p;
        if (a == T0 || b == T0) begin
            p = T0;
        end else if (a == b) begin
            p = T1;
        end else begin
            p = T2;
        end
        return p;
    endfunction

    function automatic logic [W-1:0] f3m_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            c[2*i +: 2] = f3_add(a[2*i +: 2], b[2*i +: 2]);
        end
        return c;
    endfunction

    function automatic logic [W-1:0] f3m_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            c[2*i +: 2] = f3_sub(a[2*i +: 2], b[2*i +: 2]);
        end
        return c;
    endfunction

    function automatic logic [W-1:0] f3m_scale(input logic [1:0] k, input logic [W-1:0] a);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < M; i++) begin
            c[2*i +: 2] = f3_mul(k, a[2*i +: 2]);
        end
        return c;
    endfunction

    // x^97 == -x^12 - 2 == 2x^12 + 1, so the shifted-out trit t lands as -t at 12 and t at 0
    function automatic logic [W-1:0] mul_x_mod_p(input logic [W-1:0] a);
        logic [1:0]   t;
        logic [W-1:0] c;
        t = a[2*(M-1) +: 2];
        c = {a[W-3:0], T0};
        c[2*TAP_MID +: 2] = f3_add(c[2*TAP_MID +: 2], f3_neg(t));
        c[2*TAP_LO +: 2]  = t;
        return c;
    endfunction

    // Adding u0*P clears the constant trit (u0 + 2*u0 == 0), then the exact shift divides by x
    function automatic logic [W-1:0] div_x_mod_p(input logic [W-1:0] a);
        logic [1:0]   u0;
        logic [W-1:0] c;
        u0 = a[2*TAP_LO +: 2];
        c  = {u0, a[W-1:2]};
        c[2*(TAP_MID-1) +: 2] = f3_add(c[2*(TAP_MID-1) +: 2], u0);
        return c;
    endfunction

endpackage

// File: rtl/f3m_inv_step.sv
// One combinational iteration of the ternary extended Euclid used for inversion.
// Invariant kept by the step: R == U*A*x^e and S == V*A*x^e (mod P) for a shared e.
module f3m_inv_step
    import f3m_pkg::*;
(
    input  logic [RW-1:0] s,
    input  logic [RW-1:0] r,
    input  logic [W-1:0]  u,
    input  logic [W-1:0]  v,
    input  logic [DW-1:0] d,
    output logic [RW-1:0] s_next,
    output logic [RW-1:0] r_next,
    output logic [W-1:0]  u_next,
    output logic [W-1:0]  v_next,
    output logic [DW-1:0] d_next
);

    logic [1:0]   r_top;
    logic [1:0]   s_top;
    logic [1:0]   sr;
    logic [W-1:0] s_red;
    logic [W-1:0] v_red;

    // S - s*r*R always cancels the leading trit, so only the low M trits survive
    // before the multiply by x that refills the top position.
    always_comb begin
        r_top  = r[RW-1 -: 2];
        s_top  = s[RW-1 -: 2];
        sr     = f3_mul(s_top, r_top);
        s_red  = f3m_sub(s[W-1:0], f3m_scale(sr, r[W-1:0]));
        v_red  = f3m_sub(v, f3m_scale(sr, u));

        s_next = s;
        r_next = r;
        u_next = u;
        v_next = v;
        d_next = d;

        if (r_top == T0) begin
            r_next = {r[W-1:0], T0};
            u_next = mul_x_mod_p(u);
            d_next = d + DW'(1);
        end else if (d == '0) begin
            r_next = {s_red, T0};
            s_next = r;
            u_next = mul_x_mod_p(v_red);
            v_next = u;
            d_next = DW'(1);
        end else begin
            s_next = {s_red, T0};
            v_next = v_red;
            u_next = div_x_mod_p(u);
            d_next = d - DW'(1);
        end
    end

endmodule

// File: rtl/f3m_inv_unit.sv
// GF(3^97) inverter: reset pulse starts it, 2*M Euclid iterations later C = A^-1 mod P.
// Phase sequence LOAD -> ITER -> FIN -> DONE; done rises on the 196th edge after release.
module f3m_inv_unit
    import f3m_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] A,
    output logic [W-1:0] C,
    output logic         done
);

    phase_t        phase;
    phase_t        phase_next;
    logic [RW-1:0] s_reg;
    logic [RW-1:0] r_reg;
    logic [W-1:0]  u_reg;
    logic [W-1:0]  v_reg;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] iter_cnt;
    logic [RW-1:0] s_step;
    logic [RW-1:0] r_step;
    logic [W-1:0]  u_step;
    logic [W-1:0]  v_step;
    logic [DW-1:0] d_step;

    f3m_inv_step u_step_dp (
        .s      (s_reg),
        .r      (r_reg),
        .u      (u_reg),
        .v      (v_reg),
        .d      (d_reg),
        .s_next (s_step),
        .r_next (r_step),
        .u_next (u_step),
        .v_next (v_step),
        .d_next (d_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= LOAD;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        case (phase)
            LOAD:    phase_next = ITER;
            ITER:    if (iter_cnt == DW'(ITERS - 1)) phase_next = FIN;
            FIN:     phase_next = DONE;
            DONE:    phase_next = DONE;
            default: phase_next = LOAD;
        endcase
    end

    // U starts at 1 so that R == U*A holds from the first cycle; the final
    // leading trit of R is a unit, and scaling U by it yields the inverse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_reg    <= '0;
            r_reg    <= '0;
            u_reg    <= '0;
            v_reg    <= '0;
            d_reg    <= '0;
            iter_cnt <= '0;
            C        <= '0;
            done     <= 1'b0;
        end else begin
            case (phase)
                LOAD: begin
                    s_reg    <= P_POLY;
                    r_reg    <= {T0, A};
                    u_reg    <= F_ONE;
                    v_reg    <= '0;
                    d_reg    <= '0;
                    iter_cnt <= '0;
                end
                ITER: begin
                    s_reg    <= s_step;
                    r_reg    <= r_step;
                    u_reg    <= u_step;
                    v_reg    <= v_step;
                    d_reg    <= d_step;
                    iter_cnt <= iter_cnt + DW'(1);
                end
                FIN: begin
                    C    <= f3m_scale(r_reg[RW-1 -: 2], u_reg);
                    done <= 1'b1;
                end
                default: begin
                    C    <= C;
                    done <= done;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f3m_inv_unit.sv
// Directed bench for f3m_inv_unit: known inverses, latency, abort-by-reset and
// random operands checked with an independent schoolbook multiply mod P.
module tb_f3m_inv_unit;

    localparam int M = 97;
    localparam int W = 2 * M;

    logic         clk;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] C;
    logic         done;

    int n_checks;
    int n_fails;
    int cyc;

    logic [W-1:0] a_vec;
    logic [W-1:0] exp_c;
    logic [W-1:0] one_e;

    f3m_inv_unit dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .C     (C),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain convolution followed by top-down folding with x^97 = 2x^12 + 1
    function automatic logic [W-1:0] gfMul(input logic [W-1:0] a, input logic [W-1:0] b);
        int prod [0:2*M-2];
        int c;
        logic [W-1:0] res;
        for (int i = 0; i < 2*M-1; i++) prod[i] = 0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                prod[i+j] += int'(a[2*i +: 2]) * int'(b[2*j +: 2]);
            end
        end
        for (int k = 2*M-2; k >= M; k--) begin
            c = prod[k] % 3;
            prod[k] = 0;
            prod[k-M+12] += 2 * c;
            prod[k-M]    += c;
        end
        res = '0;
        for (int i = 0; i < M; i++) res[2*i +: 2] = 2'(prod[i] % 3);
        return res;
    endfunction

    function automatic logic [W-1:0] randElem();
        logic [W-1:0] e;
        e = '0;
        for (int i = 0; i < M; i++) e[2*i +: 2] = 2'($urandom_range(0, 2));
        if (e == '0) e[1:0] = 2'b01;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a);
        @(negedge clk);
        A     = a;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        A        = '0;
        one_e    = W'(1);
        #1;
        checkOutput("reset_c", C, '0);
        checkOutput("reset_done", W'(done), W'(1'b0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        a_vec = 194'b10_01_01_10_01_00;
        exp_c = 194'h65450169824811252a919a8a02964184221a1562655252a9;
        applyStimulus(a_vec);
        waitDone(cyc);
        checkOutput("poly_latency", W'(cyc), W'(196));
        checkOutput("poly_c", C, exp_c);
        checkOutput("poly_prod", gfMul(C, a_vec), one_e);

        applyStimulus(W'(1));
        waitDone(cyc);
        checkOutput("one_latency", W'(cyc), W'(196));
        checkOutput("one_c", C, W'(1));

        applyStimulus(W'(2));
        waitDone(cyc);
        checkOutput("two_latency", W'(cyc), W'(196));
        checkOutput("two_c", C, W'(2));

        a_vec = W'(4);
        exp_c = (W'(1) << 192) | (W'(1) << 22);
        applyStimulus(a_vec);
        waitDone(cyc);
        checkOutput("x_latency", W'(cyc), W'(196));
        checkOutput("x_c", C, exp_c);
        checkOutput("x_prod", gfMul(C, a_vec), one_e);

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("drop_c", C, '0);
        checkOutput("drop_done", W'(done), W'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("mid_done_low", W'(done), W'(1'b0));

        a_vec = W'(8);
        exp_c = (W'(1) << 193) | (W'(1) << 23);
        @(negedge clk);
        A     = a_vec;
        reset = 1'b1;
        #1;
        checkOutput("abort_c", C, '0);
        checkOutput("abort_done", W'(done), W'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        waitDone(cyc);
        checkOutput("abort_latency", W'(cyc), W'(196));
        checkOutput("abort_c_new", C, exp_c);
        checkOutput("abort_prod", gfMul(C, a_vec), one_e);

        applyStimulus('0);
        waitDone(cyc);
        checkOutput("zero_latency", W'(cyc), W'(196));

        for (int n = 0; n < 200; n++) begin
            a_vec = randElem();
            applyStimulus(a_vec);
            waitDone(cyc);
            checkOutput("rand_latency", W'(cyc), W'(196));
            checkOutput("rand_prod", gfMul(C, a_vec), one_e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
